// File: rtl/timer_pkg.sv
// Shared definitions for the 8-bit APB timer: register bit positions,
// clk_sel divide table and the count controller state encoding.
`timescale 1ns/1ps
package timer_pkg;

  localparam int CNT_W_DEF = 8;
  localparam int PSC_W_DEF = 4;

  localparam int TCR_CLK_SEL_LSB = 0;
  localparam int TCR_CLK_SEL_MSB = 1;
  localparam int TCR_EN_BIT      = 4;
  localparam int TCR_DW_BIT      = 5;
  localparam int TCR_LOAD_BIT    = 7;
  localparam int TSR_OVF_BIT     = 0;
  localparam int TSR_UDF_BIT     = 1;

  typedef enum logic [1:0] {
    CLK_DIV2  = 2'b00,
    CLK_DIV4  = 2'b01,
    CLK_DIV8  = 2'b10,
    CLK_DIV16 = 2'b11
  } clk_sel_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_e;

  // Divide ratio N = 2 << clk_sel, i.e. 2/4/8/16
  function automatic logic [4:0] divRatio(input logic [1:0] sel);
    return 5'd2 << sel;
  endfunction

endpackage

// File: rtl/timer_cnt_ctrl_if.sv
// Control/status bundle between the timer register file and the count
// controller: decoded TCR fields and TDR in, TCNT/TSR/tick out.
`timescale 1ns/1ps
interface timer_cnt_ctrl_if #(
  parameter int CNT_W = 8
);
  logic             en;
  logic             dw;
  logic             load;
  logic [1:0]       clk_sel;
  logic [CNT_W-1:0] tdr;
  logic             clr_ovf;
  logic             clr_udf;
  logic [CNT_W-1:0] cnt;
  logic             ovf;
  logic             udf;
  logic             tick;

  modport master (
    output en, dw, load, clk_sel, tdr, clr_ovf, clr_udf,
    input  cnt, ovf, udf, tick
  );

  modport slave (
    input  en, dw, load, clk_sel, tdr, clr_ovf, clr_udf,
    output cnt, ovf, udf, tick
  );
endinterface

// File: rtl/timer_prescaler.sv
// Prescaler for the timer count controller: divides pclk by 2/4/8/16 and
// restarts its period whenever clk_sel changes or counting stops.
`timescale 1ns/1ps
module timer_prescaler
  import timer_pkg::*;
#(
  parameter int PSC_W = PSC_W_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_run,
  input  logic [1:0] i_clkSel,
  output logic       o_tick
);

  logic [PSC_W-1:0] r_divCnt;
  logic [1:0]       r_clkSelQ;
  logic [PSC_W-1:0] w_divLast;
  logic             w_selChanged;

  assign w_divLast    = PSC_W'(divRatio(i_clkSel) - 5'd1);
  assign w_selChanged = (i_clkSel != r_clkSelQ);
  assign o_tick       = i_run && !w_selChanged && (r_divCnt == w_divLast);

  // A clk_sel change discards the partial period rather than finishing it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_divCnt  <= '0;
      r_clkSelQ <= 2'b00;
    end else begin
      r_clkSelQ <= i_clkSel;
      if (!i_run || w_selChanged || o_tick) begin
        r_divCnt <= '0;
      end else begin
        r_divCnt <= r_divCnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/timer_cnt_ctrl.sv
// Timer count controller: load/up/down sequencing of TCNT plus the sticky
// overflow and underflow flags.
`timescale 1ns/1ps
module timer_cnt_ctrl
  import timer_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int PSC_W = PSC_W_DEF
) (
  input logic              pclk,
  input logic              prst,
  timer_cnt_ctrl_if.slave  bus
);

  state_e           r_state;
  state_e           w_stateNext;
  logic             w_run;
  logic             w_pscTick;
  logic             w_tick;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;
  logic             r_udf;
  logic             w_wrapUp;
  logic             w_wrapDown;

  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Load has priority over counting; decisions follow the current inputs
  always_comb begin
    w_stateNext = IDLE;
    w_run       = 1'b0;
    if (bus.load) begin
      w_stateNext = LOAD;
    end else if (bus.en) begin
      w_stateNext = RUN;
      w_run       = 1'b1;
    end
  end

  timer_prescaler #(
    .PSC_W (PSC_W)
  ) u_prescaler (
    .clk      (pclk),
    .rst      (prst),
    .i_run    (w_run),
    .i_clkSel (bus.clk_sel),
    .o_tick   (w_pscTick)
  );

  assign w_tick     = w_pscTick && (r_state == RUN);
  assign w_wrapUp   = w_tick && !bus.dw && (r_cnt == {CNT_W{1'b1}});
  assign w_wrapDown = w_tick &&  bus.dw && (r_cnt == '0);

  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      r_cnt <= '0;
    end else if (bus.load) begin
      r_cnt <= bus.tdr;
    end else if (w_tick) begin
      r_cnt <= bus.dw ? r_cnt - 1'b1 : r_cnt + 1'b1;
    end
  end

  // A wrap on the same cycle as a clear pulse leaves the flag set
  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      if (w_wrapUp) begin
        r_ovf <= 1'b1;
      end else if (bus.clr_ovf) begin
        r_ovf <= 1'b0;
      end
      if (w_wrapDown) begin
        r_udf <= 1'b1;
      end else if (bus.clr_udf) begin
        r_udf <= 1'b0;
      end
    end
  end

  assign bus.cnt  = r_cnt;
  assign bus.ovf  = r_ovf;
  assign bus.udf  = r_udf;
  assign bus.tick = w_tick;

endmodule

// File: tb/tb_timer_cnt_ctrl.sv
// Directed bench for timer_cnt_ctrl: reset, long up-count overflow, load and
// down-count underflow, prescaler periods and flag/load corner cases.
`timescale 1ns/1ps
module tb_timer_cnt_ctrl;

  logic pclk;
  logic prst;
  int   total;
  int   bad;

  timer_cnt_ctrl_if #(.CNT_W(8)) bus ();

  timer_cnt_ctrl #(
    .CNT_W (8),
    .PSC_W (4)
  ) dut (
    .pclk (pclk),
    .prst (prst),
    .bus  (bus)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic applyStimulus(input logic en, input logic dw, input logic load,
                               input logic [1:0] sel, input logic [7:0] tdr,
                               input logic clrOvf, input logic clrUdf);
    bus.en      = en;
    bus.dw      = dw;
    bus.load    = load;
    bus.clk_sel = sel;
    bus.tdr     = tdr;
    bus.clr_ovf = clrOvf;
    bus.clr_udf = clrUdf;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance n rising edges, landing 1ns after the last one
  task automatic stepEdges(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  initial begin
    int firstTick;
    int secondTick;
    total = 0;
    bad   = 0;
    prst  = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0);
    stepEdges(2);
    checkOutput("rst_cnt", 32'(bus.cnt), 32'h00);
    checkOutput("rst_ovf", 32'(bus.ovf), 32'h0);
    checkOutput("rst_udf", 32'(bus.udf), 32'h0);
    checkOutput("rst_tick", 32'(bus.tick), 32'h0);
    prst = 1'b0;
    stepEdges(1);

    // Up-count /8 from 00
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b10, 8'h00, 1'b0, 1'b0);
    stepEdges(1);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b10, 8'h00, 1'b0, 1'b0);
    stepEdges(1760);
    checkOutput("up1760_cnt", 32'(bus.cnt), 32'hDC);
    checkOutput("up1760_ovf", 32'(bus.ovf), 32'h0);
    stepEdges(287);
    checkOutput("up2047_cnt", 32'(bus.cnt), 32'hFF);
    checkOutput("up2047_tick", 32'(bus.tick), 32'h1);
    stepEdges(1);
    checkOutput("up2048_cnt", 32'(bus.cnt), 32'h00);
    checkOutput("up2048_ovf", 32'(bus.ovf), 32'h1);
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b10, 8'h00, 1'b1, 1'b0);
    stepEdges(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b10, 8'h00, 1'b0, 1'b0);
    checkOutput("clr_ovf", 32'(bus.ovf), 32'h0);
    checkOutput("idle_hold", 32'(bus.cnt), 32'h00);

    // Load 03 then down-count /2
    applyStimulus(1'b0, 1'b1, 1'b1, 2'b00, 8'h03, 1'b0, 1'b0);
    stepEdges(1);
    checkOutput("load03", 32'(bus.cnt), 32'h03);
    applyStimulus(1'b1, 1'b1, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0);
    stepEdges(2);
    checkOutput("dn_02", 32'(bus.cnt), 32'h02);
    stepEdges(2);
    checkOutput("dn_01", 32'(bus.cnt), 32'h01);
    stepEdges(2);
    checkOutput("dn_00", 32'(bus.cnt), 32'h00);
    stepEdges(2);
    checkOutput("dn_FF", 32'(bus.cnt), 32'hFF);
    checkOutput("dn_udf", 32'(bus.udf), 32'h1);
    checkOutput("dn_ovf", 32'(bus.ovf), 32'h0);

    // Asynchronous reset while running
    #2;
    prst = 1'b1;
    #1;
    checkOutput("arst_cnt", 32'(bus.cnt), 32'h00);
    checkOutput("arst_ovf", 32'(bus.ovf), 32'h0);
    checkOutput("arst_udf", 32'(bus.udf), 32'h0);
    checkOutput("arst_tick", 32'(bus.tick), 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0);
    #3;
    prst = 1'b0;
    stepEdges(1);

    // Tick period for every divide ratio, starting from idle
    for (int sel = 0; sel < 4; sel++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 2'(sel), 8'h00, 1'b0, 1'b0);
      stepEdges(1);
      applyStimulus(1'b1, 1'b0, 1'b0, 2'(sel), 8'h00, 1'b0, 1'b0);
      firstTick  = -1;
      secondTick = -1;
      for (int e = 1; e <= 40; e++) begin
        stepEdges(1);
        if (bus.tick === 1'b1) begin
          if (firstTick < 0) firstTick = e;
          else if (secondTick < 0) secondTick = e;
        end
      end
      checkOutput($sformatf("first_tick_sel%0d", sel), 32'(firstTick), 32'((2 << sel) - 1));
      checkOutput($sformatf("period_sel%0d", sel), 32'(secondTick - firstTick), 32'(2 << sel));
    end

    // clk_sel change mid-period restarts the prescaler
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b11, 8'h00, 1'b0, 1'b0);
    stepEdges(1);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b11, 8'h00, 1'b0, 1'b0);
    stepEdges(5);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0);
    #1;
    checkOutput("chg_tick_now", 32'(bus.tick), 32'h0);
    stepEdges(1);
    checkOutput("chg_tick_e1", 32'(bus.tick), 32'h0);
    stepEdges(1);
    checkOutput("chg_tick_e2", 32'(bus.tick), 32'h1);

    // Clear pulse coinciding with FF->00 wrap: set wins
    applyStimulus(1'b0, 1'b0, 1'b1, 2'b00, 8'hFF, 1'b0, 1'b0);
    stepEdges(1);
    checkOutput("loadFF", 32'(bus.cnt), 32'hFF);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0);
    stepEdges(1);
    checkOutput("wrap_tick", 32'(bus.tick), 32'h1);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 8'h00, 1'b1, 1'b0);
    stepEdges(1);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0);
    checkOutput("wrapclr_cnt", 32'(bus.cnt), 32'h00);
    checkOutput("wrapclr_ovf", 32'(bus.ovf), 32'h1);

    // Load during RUN suppresses ticks and restarts the prescaler
    stepEdges(3);
    applyStimulus(1'b1, 1'b0, 1'b1, 2'b00, 8'h55, 1'b0, 1'b0);
    #1;
    checkOutput("ldrun_tick", 32'(bus.tick), 32'h0);
    stepEdges(1);
    checkOutput("ldrun_cnt1", 32'(bus.cnt), 32'h55);
    stepEdges(1);
    checkOutput("ldrun_cnt2", 32'(bus.cnt), 32'h55);
    checkOutput("ldrun_tick2", 32'(bus.tick), 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0);
    stepEdges(1);
    checkOutput("ldrun_e1_cnt", 32'(bus.cnt), 32'h55);
    checkOutput("ldrun_e1_tick", 32'(bus.tick), 32'h1);
    stepEdges(1);
    checkOutput("ldrun_e2_cnt", 32'(bus.cnt), 32'h56);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/timer_cnt_ctrl.md
# timer_cnt_ctrl

Count controller for the 8-bit APB timer. Owns the prescaler, the TCNT count register and the sticky overflow/underflow flags. Sequences load, up-count and down-count according to the TCR fields decoded by the register file. Sits between the APB register file (TCR/TDR/TSR) and the interrupt logic.

## Interface
Parameters:
- CNT_W, 8, counter width (TCNT/TDR)
- PSC_W, 4, prescaler width; must cover the largest divide ratio (16)

Ports:
- pclk  in  1  system clock
- prst  in  1  asynchronous, active-high reset
- en  in  1  TCR[4]; count enable
- dw  in  1  TCR[5]; 0 = count up, 1 = count down
- load  in  1  TCR[7]; level load request
- clk_sel  in  2  TCR[1:0]; 00 = /2, 01 = /4, 10 = /8, 11 = /16
- tdr  in  CNT_W  load value
- clr_ovf  in  1  one-cycle pulse; register file writes 0 to TSR[0]
- clr_udf  in  1  one-cycle pulse; register file writes 0 to TSR[1]
- cnt  out  CNT_W  TCNT value
- ovf  out  1  TSR[0], sticky
- udf  out  1  TSR[1], sticky
- tick  out  1  count-enable pulse, one pclk wide

## Operation
- FSM state_q ∈ {IDLE, LOAD, RUN}. Next state, priority order:
  - load=1 → LOAD
  - else en=1 → RUN
  - else IDLE
- Evaluation is every pclk; all decisions use current inputs.
- LOAD:
  - cnt ← tdr on every cycle load is high.
  - Prescaler cleared; tick=0; flags untouched.
- IDLE:
  - cnt holds.
  - Prescaler cleared; tick=0.
- RUN:
  - Prescaler div_cnt increments every pclk.
  - tick = (div_cnt == N−1), where N = 2 << clk_sel.
  - On the tick cycle, div_cnt ← 0.
  - On tick, cnt ← cnt+1 (dw=0) or cnt−1 (dw=1), modulo 2^CNT_W.
- Wrap-around:
  - Up-count tick with cnt=FF → cnt=00 and ovf←1.
  - Down-count tick with cnt=00 → cnt=FF and udf←1.
- Flags are sticky until their clr pulse. Simultaneous set and clr in one cycle: set wins, flag stays 1.
- clk_sel change while in RUN: div_cnt ← 0 on the cycle the registered clk_sel differs. No tick on that cycle.
- dw change mid-period: no prescaler restart; applies at the next tick.
- Entry into RUN (from IDLE or LOAD) always starts with div_cnt=0.

## Timing
- Reset values: state_q=IDLE, div_cnt=0, cnt=00, ovf=0, udf=0, tick=0, clk_sel shadow=00.
- tick is combinational from div_cnt, state and clk_sel. All other outputs are registered.
- Counting latency: with en sampled high at edge 1 (and load low), the first increment is visible after edge N. Increment k is visible after edge k·N.
- Up-count from 00, /8: ovf rises after edge 8·256 = 2048. At edge 8·220 = 1760, cnt=DC and ovf=0.
- Load: cnt=tdr one edge after load is sampled high.
- Clear: flag reads 0 one edge after the clr pulse.
- Reset mid-operation: all state returns to reset values immediately, independent of pclk.

## Structure
- Shared package timer_pkg:
  - clk_sel encodings and divide table (2/4/8/16)
  - state enum {IDLE, LOAD, RUN}
  - TCR/TSR bit positions
  - CNT_W default
- One sub-module: timer_prescaler. Inputs: run, clk_sel. Outputs: tick. It owns div_cnt and clk_sel change detection.
- The FSM, count register and flags live in timer_cnt_ctrl.

## Test plan
- Reset → cnt=00, ovf=0, udf=0, tick=0. Assert prst mid-RUN → same values asynchronously.
- en=1, dw=0, clk_sel=10 from cnt=00:
  - at edge 1760: cnt=DC, ovf=0
  - at edge 2048: cnt=00, ovf=1
  - clr_ovf pulse → ovf=0 next edge
- load=1 with tdr=03 for one cycle, then en=1, dw=1, clk_sel=00:
  - cnt 03→02→01→00 every 2 edges
  - next tick: cnt=FF, udf=1
  - ovf stays 0
- Each clk_sel 00/01/10/11 with en=1: tick period is 2/4/8/16 edges. A clk_sel change mid-period restarts the period from 0.
- Flag corner cases:
  - clr_ovf asserted on the same cycle as the FF→00 tick → ovf=1.
  - load asserted during RUN → no tick, cnt=tdr, prescaler restarts when load drops.
